// File: rtl/pc8001_pkg.sv
// Shared types and constants for the PC-8001 system SRAM arbiter.
// The arbiter state enum is shared so a bench can decode the debug state port.
package pc8001_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_OWN   = 2'd1,
        CPU_DEFER = 2'd2
    } arb_state_t;

    localparam int DEF_WAIT_NORM = 18;
    localparam int DEF_WAIT_FAST = 12;
    localparam int DEF_CPU_SLOTS = 3;

    localparam int CNT_W  = 5;
    localparam int SLOT_W = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/cpu_wait_timer.sv
// CPU wait-state timer: saturating cycle counter, per-cycle speed latch and
// waitreq generation.
module cpu_wait_timer
    import pc8001_pkg::*;
#(
    parameter int WAIT_NORM = DEF_WAIT_NORM,
    parameter int WAIT_FAST = DEF_WAIT_FAST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_oc,
    input  logic             start,
    input  logic             cpu_start,
    input  logic             deferred,
    output logic             waitreq,
    output logic [CNT_W-1:0] cnt
);

    // The cycle that clears the counter is clock 0 of the CPU cycle, so the
    // registered count lags the cycle position by one.
    localparam logic [CNT_W-1:0] LIM_NORM = CNT_W'(WAIT_NORM - 1);
    localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(WAIT_FAST - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             fast_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            fast_q <= 1'b0;
        end else begin
            if (start) begin
                fast_q <= sw_oc;
            end
            if (start || deferred) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign waitreq = cpu_start | deferred | (cnt_q < (fast_q ? LIM_FAST : LIM_NORM));
    assign cnt     = cnt_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Slot-interleaved arbiter for the single-port system SRAM: CPU memory cycles
// own the SRAM for CPU_SLOTS clocks, DMA bytes are fetched in idle clocks.
module sram_bus_arbiter
    import pc8001_pkg::*;
#(
    parameter int WAIT_NORM = DEF_WAIT_NORM,
    parameter int WAIT_FAST = DEF_WAIT_FAST,
    parameter int CPU_SLOTS = DEF_CPU_SLOTS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_oc,
    input  logic             cpu_start,
    input  logic             cpu_mreq,
    input  logic             cpu_wr,
    input  logic             cpu_wr_ok,
    input  logic [15:0]      cpu_adr,
    output logic             waitreq,
    input  logic             dma_req,
    input  logic             dma_urgent,
    input  logic [15:0]      dma_adr,
    output logic             dma_ack,
    output logic             dma_valid,
    output logic [15:0]      ram_adr,
    output logic             ram_we,
    output logic [1:0]       state_dbg,
    output logic [CNT_W-1:0] cnt_dbg
);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CPU_SLOTS - 1);
    localparam logic [SLOT_W-1:0] SLOT_WE   = SLOT_W'(1);

    arb_state_t        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              grant;
    logic              we_c;
    logic              start_ok;
    logic              dma_valid_q;

    // DMA handshake: dma_req is a level held until the cycle in which
    // dma_ack=1; dma_adr is sampled in that cycle and the SRAM byte is on
    // ram_q one clock later, flagged by dma_valid.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        grant   = 1'b0;
        we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_start && cpu_mreq) begin
                    if (dma_req && dma_urgent) begin
                        grant   = 1'b1;
                        state_d = CPU_DEFER;
                    end else begin
                        state_d = CPU_OWN;
                        slot_d  = '0;
                    end
                end else if (dma_req) begin
                    grant = 1'b1;
                end
            end
            CPU_DEFER: begin
                state_d = CPU_OWN;
                slot_d  = '0;
            end
            CPU_OWN: begin
                we_c = (slot_q == SLOT_WE) & cpu_wr & cpu_wr_ok;
                if (slot_q == SLOT_LAST) begin
                    state_d = IDLE;
                    slot_d  = '0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            dma_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            dma_valid_q <= dma_ack;
        end
    end

    assign dma_ack   = grant & ~reset;
    assign ram_we    = we_c & ~reset;
    assign ram_adr   = dma_ack ? dma_adr : cpu_adr;
    assign dma_valid = dma_valid_q;
    assign state_dbg = state_q;

    // A new CPU cycle can only begin outside an ownership window.
    assign start_ok = cpu_start & (state_q == IDLE);

    cpu_wait_timer #(
        .WAIT_NORM (WAIT_NORM),
        .WAIT_FAST (WAIT_FAST)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .sw_oc     (sw_oc),
        .start     (start_ok),
        .cpu_start (cpu_start),
        .deferred  (state_q == CPU_DEFER),
        .waitreq   (waitreq),
        .cnt       (cnt_dbg)
    );

    a_no_start_in_own : assert property (@(posedge clk) disable iff (reset)
        !(cpu_start && state_q == CPU_OWN));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scenario bench for sram_bus_arbiter: DMA addresses go through an expected
// queue, CPU timing is checked against constants derived from the cycle plan.
module tb_sram_bus_arbiter;
    import pc8001_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sw_oc;
    logic        cpu_start;
    logic        cpu_mreq;
    logic        cpu_wr;
    logic        cpu_wr_ok;
    logic [15:0] cpu_adr;
    logic        waitreq;
    logic        dma_req;
    logic        dma_urgent;
    logic [15:0] dma_adr;
    logic        dma_ack;
    logic        dma_valid;
    logic [15:0] ram_adr;
    logic        ram_we;
    logic [1:0]  state_dbg;
    logic [4:0]  cnt_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    sram_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .sw_oc      (sw_oc),
        .cpu_start  (cpu_start),
        .cpu_mreq   (cpu_mreq),
        .cpu_wr     (cpu_wr),
        .cpu_wr_ok  (cpu_wr_ok),
        .cpu_adr    (cpu_adr),
        .waitreq    (waitreq),
        .dma_req    (dma_req),
        .dma_urgent (dma_urgent),
        .dma_adr    (dma_adr),
        .dma_ack    (dma_ack),
        .dma_valid  (dma_valid),
        .ram_adr    (ram_adr),
        .ram_we     (ram_we),
        .state_dbg  (state_dbg),
        .cnt_dbg    (cnt_dbg)
    );

    // ---- clock / reset ----
    always #35 clk = ~clk;

    // ---- driver tasks ----
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_start  = 1'b0;
        cpu_mreq   = 1'b0;
        cpu_wr     = 1'b0;
        cpu_wr_ok  = 1'b0;
        dma_req    = 1'b0;
        dma_urgent = 1'b0;
    endtask

    task automatic drive_cpu(input logic mreq, input logic wr, input logic wr_ok,
                             input logic [15:0] adr);
        cpu_start = 1'b1;
        cpu_mreq  = mreq;
        cpu_wr    = wr;
        cpu_wr_ok = wr_ok;
        cpu_adr   = adr;
    endtask

    task automatic push_dma(input logic [15:0] adr);
        dma_req = 1'b1;
        dma_adr = adr;
        exp_q.push_back(adr);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [15:0] exp;
        reset   = 1'b1;
        sw_oc   = 1'b0;
        idle_inputs();
        cpu_adr = 16'h1234;
        dma_adr = 16'h0000;
        repeat (4) tick();
        #1;
        n_tests++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
        n_tests++;
        if (cnt_dbg !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_dbg); end
        n_tests++;
        if (waitreq !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq: got %b expected 1", waitreq); end
        n_tests++;
        if (dma_ack !== 1'b0 || dma_valid !== 1'b0 || ram_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: ack=%b valid=%b we=%b expected 0 0 0", dma_ack, dma_valid, ram_we);
        end
        exp = 16'h1234;
        n_tests++;
        if (ram_adr !== exp) begin n_fail++; $display("FAIL reset_ram_adr: got %h expected %h", ram_adr, exp); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_read();
        int wait_hi = 0;
        int first_low = -1;
        int we_cnt = 0;
        repeat (20) tick();
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b0, 1'b0, 16'h8000);
            else cpu_start = 1'b0;
            #1;
            if (waitreq === 1'b1) wait_hi++;
            else if (first_low < 0) first_low = i;
            if (ram_we !== 1'b0) we_cnt++;
            if (i >= 1 && i <= 3) begin
                n_tests++;
                if (state_dbg !== CPU_OWN || ram_adr !== 16'h8000) begin
                    n_fail++; $display("FAIL read_own[%0d]: state=%0d adr=%h expected %0d 8000", i, state_dbg, ram_adr, CPU_OWN);
                end
            end
        end
        n_tests++;
        if (wait_hi != 18 || first_low != 18) begin
            n_fail++; $display("FAIL read_waitreq: high=%0d first_low=%0d expected 18 18", wait_hi, first_low);
        end
        n_tests++;
        if (we_cnt != 0) begin n_fail++; $display("FAIL read_we: pulses=%0d expected 0", we_cnt); end
        n_tests++;
        if (state_dbg !== IDLE) begin n_fail++; $display("FAIL read_end_state: got %0d expected %0d", state_dbg, IDLE); end
        idle_inputs();
    endtask

    task automatic test_write(input logic wr_ok);
        int we_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b1, wr_ok, 16'hC000);
            else cpu_start = 1'b0;
            #1;
            if (ram_we === 1'b1) we_cnt++;
            if (i == 2) begin
                n_tests++;
                if (ram_we !== wr_ok) begin n_fail++; $display("FAIL write_slot1 ok=%b: we=%b expected %b", wr_ok, ram_we, wr_ok); end
            end
        end
        n_tests++;
        if (we_cnt != int'(wr_ok)) begin
            n_fail++; $display("FAIL write_pulses ok=%b: got %0d expected %0d", wr_ok, we_cnt, int'(wr_ok));
        end
        idle_inputs();
    endtask

    task automatic test_io_dma();
        logic [15:0] exp;
        tick();
        drive_cpu(1'b0, 1'b0, 1'b0, 16'h0040);
        push_dma(16'hF200);
        #1;
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++; $display("FAIL io_dma_ack: got %b expected 1", dma_ack);
        end else begin
            exp = exp_q.pop_front();
            if (ram_adr !== exp) begin n_fail++; $display("FAIL io_dma_adr: got %h expected %h", ram_adr, exp); end
        end
        tick();
        idle_inputs();
        #1;
        n_tests++;
        if (state_dbg !== IDLE || dma_valid !== 1'b1 || waitreq !== 1'b1) begin
            n_fail++; $display("FAIL io_after: state=%0d valid=%b waitreq=%b expected 0 1 1", state_dbg, dma_valid, waitreq);
        end
    endtask

    // DMA request raised at cycle req_at of a CPU read; the byte must be
    // granted in the first IDLE clock after the three ownership slots.
    task automatic test_dma_slot(input int req_at);
        logic [15:0] exp;
        logic acked = 1'b0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b0, 1'b0, 16'h8100);
            else cpu_start = 1'b0;
            if (acked) dma_req = 1'b0;
            if (i == req_at) push_dma(16'hF300 + 16'(req_at));
            #1;
            n_tests++;
            if (dma_ack !== (i == 4)) begin
                n_fail++; $display("FAIL dma_slot%0d_ack[%0d]: got %b expected %b", req_at, i, dma_ack, (i == 4));
            end
            n_tests++;
            if (dma_valid !== (i == 5)) begin
                n_fail++; $display("FAIL dma_slot%0d_valid[%0d]: got %b expected %b", req_at, i, dma_valid, (i == 5));
            end
            if (dma_ack === 1'b1 && exp_q.size() > 0) begin
                acked = 1'b1;
                exp = exp_q.pop_front();
                n_tests++;
                if (ram_adr !== exp) begin n_fail++; $display("FAIL dma_slot%0d_adr: got %h expected %h", req_at, ram_adr, exp); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_urgent();
        logic [15:0] exp;
        int wait_hi = 0;
        arb_state_t exp_st;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (i == 0) begin
                drive_cpu(1'b1, 1'b0, 1'b0, 16'h8200);
                push_dma(16'hF400);
                dma_urgent = 1'b1;
            end else begin
                cpu_start  = 1'b0;
                dma_req    = 1'b0;
                dma_urgent = 1'b0;
            end
            #1;
            if (waitreq === 1'b1) wait_hi++;
            if (i == 0) begin
                n_tests++;
                if (dma_ack !== 1'b1) begin
                    n_fail++; $display("FAIL urgent_ack: got %b expected 1", dma_ack);
                end else begin
                    exp = exp_q.pop_front();
                    if (ram_adr !== exp) begin n_fail++; $display("FAIL urgent_adr: got %h expected %h", ram_adr, exp); end
                end
            end
            if (i >= 1 && i <= 5) begin
                exp_st = (i == 1) ? CPU_DEFER : (i == 5) ? IDLE : CPU_OWN;
                n_tests++;
                if (state_dbg !== exp_st || dma_ack !== 1'b0) begin
                    n_fail++; $display("FAIL urgent_state[%0d]: state=%0d ack=%b expected %0d 0", i, state_dbg, dma_ack, exp_st);
                end
            end
            if (i == 1) begin
                n_tests++;
                if (dma_valid !== 1'b1) begin n_fail++; $display("FAIL urgent_valid: got %b expected 1", dma_valid); end
            end
        end
        n_tests++;
        if (wait_hi != 19) begin n_fail++; $display("FAIL urgent_waitreq: high=%0d expected 19", wait_hi); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b0, 1'b0, 16'h8300);
            else if (i == 4) drive_cpu(1'b1, 1'b0, 1'b0, 16'h8400);
            else cpu_start = 1'b0;
            #1;
            if (i >= 5 && i <= 7) begin
                n_tests++;
                if (state_dbg !== CPU_OWN || ram_adr !== 16'h8400) begin
                    n_fail++; $display("FAIL b2b_own[%0d]: state=%0d adr=%h expected %0d 8400", i, state_dbg, ram_adr, CPU_OWN);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b1, 1'b1, 16'hC100);
            else cpu_start = 1'b0;
            if (i == 3) begin
                reset = 1'b0;
                idle_inputs();
            end
            #1;
            if (i == 2) begin
                n_tests++;
                if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rmid_we_before: got %b expected 1", ram_we); end
                reset = 1'b1;
            end
        end
        n_tests++;
        if (ram_we !== 1'b0 || state_dbg !== IDLE || waitreq !== 1'b1 || dma_valid !== 1'b0 || cnt_dbg !== 5'd0) begin
            n_fail++; $display("FAIL rmid_after: we=%b state=%0d waitreq=%b valid=%b cnt=%0d expected 0 0 1 0 0",
                               ram_we, state_dbg, waitreq, dma_valid, cnt_dbg);
        end
        tick();
        reset   = 1'b1;
        dma_req = 1'b1;
        dma_adr = 16'hF500;
        #1;
        n_tests++;
        if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_in_reset: got %b expected 0", dma_ack); end
        tick();
        reset = 1'b0;
        exp_q.push_back(16'hF500);
        #1;
        n_tests++;
        if (dma_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_suppressed: got %b expected 0", dma_valid); end
        n_tests++;
        if (dma_ack !== 1'b1) begin
            n_fail++; $display("FAIL rmid_ack_after: got %b expected 1", dma_ack);
        end else begin
            exp = exp_q.pop_front();
            if (ram_adr !== exp) begin n_fail++; $display("FAIL rmid_adr: got %h expected %h", ram_adr, exp); end
        end
        tick();
        dma_req = 1'b0;
        #1;
        n_tests++;
        if (dma_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_valid: got %b expected 1", dma_valid); end
    endtask

    task automatic test_fast();
        int wait_hi = 0;
        repeat (20) tick();
        sw_oc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) drive_cpu(1'b1, 1'b0, 1'b0, 16'h9000);
            else cpu_start = 1'b0;
            #1;
            if (waitreq === 1'b1) wait_hi++;
        end
        n_tests++;
        if (wait_hi != 12) begin n_fail++; $display("FAIL fast_waitreq: high=%0d expected 12", wait_hi); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        repeat (40) tick();
        #1;
        n_tests++;
        if (cnt_dbg !== 5'd31 || waitreq !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold: cnt=%0d waitreq=%b expected 31 0", cnt_dbg, waitreq);
        end
        tick();
        #1;
        n_tests++;
        if (cnt_dbg !== 5'd31) begin n_fail++; $display("FAIL sat_no_wrap: cnt=%0d expected 31", cnt_dbg); end
        sw_oc = 1'b0;
    endtask

    // ---- sequence and final report ----
    initial begin
        test_reset();
        test_read();
        test_write(1'b1);
        test_write(1'b0);
        test_io_dma();
        test_dma_slot(2);
        test_dma_slot(0);
        test_urgent();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        test_saturation();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
